// File: rtl/pc_seq_unit.sv
// Program counter with sequential/branch/jump/call/return selection and a circular return-address stack.
// One-cycle update latency: controls sampled at an edge appear on pc after that edge; stall holds all state.
module pc_seq_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      INC       = 1,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             br_taken,
  input  logic [WIDTH-1:0]                 br_offset,
  input  logic                             jmp,
  input  logic                             call,
  input  logic [WIDTH-1:0]                 jmp_target,
  input  logic                             ret,
  output logic [WIDTH-1:0]                 pc,
  output logic [WIDTH-1:0]                 pc_plus,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ret_fault
);

  localparam int unsigned      CW    = $clog2(RAS_DEPTH + 1);
  localparam int unsigned      PW    = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);
  localparam logic [CW-1:0]    FULL  = CW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_CALL,
    SEL_RET,
    SEL_FAULT,
    SEL_HOLD
  } sel_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    sp_q, sp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [PW-1:0]    sp_dec;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;
  logic             push;
  sel_e             sel;

  assign pc_plus   = pc_q + INC_W;
  assign sp_dec    = sp_q - PW'(1);
  assign ras_top   = ras_q[sp_dec];
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == FULL);

  // Fixed priority; a ret against an empty stack degrades to a sequential step plus fault.
  always_comb begin
    sel = SEL_SEQ;
    if (stall)         sel = SEL_HOLD;
    else if (ret)      sel = ras_empty ? SEL_FAULT : SEL_RET;
    else if (call)     sel = SEL_CALL;
    else if (jmp)      sel = SEL_JMP;
    else if (br_taken) sel = SEL_BR;
  end

  always_comb begin
    pc_d    = pc_plus;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    fault_d = 1'b0;
    push    = 1'b0;
    unique case (sel)
      SEL_HOLD: begin
        pc_d = pc_q;
      end
      SEL_RET: begin
        pc_d  = ras_top;
        sp_d  = sp_dec;
        cnt_d = cnt_q - CW'(1);
      end
      SEL_FAULT: begin
        fault_d = 1'b1;
      end
      SEL_CALL: begin
        // When full the write slot is the oldest entry, so the stack wraps without moving data.
        pc_d = jmp_target;
        push = 1'b1;
        sp_d = sp_q + PW'(1);
        if (!ras_full) cnt_d = cnt_q + CW'(1);
      end
      SEL_JMP: begin
        pc_d = jmp_target;
      end
      SEL_BR: begin
        pc_d = pc_q + br_offset;
      end
      default: begin
        pc_d = pc_plus;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      sp_q    <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Stack storage carries no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (push && !reset) ras_q[sp_q] <= pc_plus;
  end

  assign pc        = pc_q;
  assign ras_count = cnt_q;
  assign ret_fault = fault_q;

endmodule
